regfile_sync_mp: RTL and testbench

Clocked, parametrised multi-port register file for the receiver datapath. It is the next generation of the combinational-read latch register file. It provides:
- NUM_RD registered read ports with write-first bypass.
- One synchronous write port.
- An optional hardwired zero register.
- A sequenced bulk-clear engine that zeroes the array one entry per cycle without a global reset.

---
 rtl/regfile_sync_mp_pkg.sv | 6 +
 rtl/regfile_rd_port.sv | 29 ++
 rtl/regfile_sync_mp.sv | 66 ++++++
 tb/tb_regfile_sync_mp.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/regfile_sync_mp_pkg.sv
// regfile_sync_mp_pkg: default widths and clear-FSM encoding shared by the register file
package regfile_sync_mp_pkg;
  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_ADDR_WIDTH = 5;
  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} clr_state_e;
endpackage

// File: rtl/regfile_rd_port.sv
// regfile_rd_port: one registered read port with zero-reg / clear / write-first bypass priority
module regfile_rd_port
  import regfile_sync_mp_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int ZERO_REG   = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  clr_act,
  input  logic [ADDR_WIDTH-1:0] clr_addr,
  input  logic                  wr_act,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic [DATA_WIDTH-1:0] data
);
  logic [DATA_WIDTH-1:0] nxt;
  always_comb
    nxt = (ZERO_REG != 0 && addr == '0)   ? '0 :
          (clr_act && clr_addr == addr)   ? '0 :
          (wr_act && wr_addr == addr)     ? wr_data : mem_data;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) data <= '0;
    else if (en) data <= nxt;
endmodule

// File: rtl/regfile_sync_mp.sv
// regfile_sync_mp: multi-port register file with registered reads, one write port and a bulk-clear sweep
module regfile_sync_mp
  import regfile_sync_mp_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int NUM_RD     = 3,
  parameter int ZERO_REG   = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_RD-1:0]            rd_en,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_RD*DATA_WIDTH-1:0] rd_data,
  input  logic                         wr_en,
  input  logic [ADDR_WIDTH-1:0]        wr_addr,
  input  logic [DATA_WIDTH-1:0]        wr_data,
  input  logic                         clr_req,
  output logic                         busy,
  output logic                         wr_drop
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  clr_state_e            state;
  logic [ADDR_WIDTH-1:0] ptr;
  logic                  wr_ok;
  assign busy  = (state == CLEAR);
  assign wr_ok = wr_en && !busy && !(ZERO_REG != 0 && wr_addr == '0);
  // ptr wraps to 0 on the last sweep edge, which is also the exit condition
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state   <= IDLE;
      ptr     <= '0;
      wr_drop <= 1'b0;
    end else begin
      wr_drop <= wr_en && busy;
      state   <= (state == IDLE) ? (clr_req ? CLEAR : IDLE) : (&ptr ? IDLE : CLEAR);
      ptr     <= busy ? ptr + 1'b1 : '0;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (busy) mem[ptr] <= '0;
      if (wr_ok) mem[wr_addr] <= wr_data;
    end
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    regfile_rd_port #(
      .DATA_WIDTH(DATA_WIDTH),
      .ADDR_WIDTH(ADDR_WIDTH),
      .ZERO_REG  (ZERO_REG)
    ) u_port (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (rd_en[k]),
      .addr    (rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH]),
      .clr_act (busy),
      .clr_addr(ptr),
      .wr_act  (wr_ok),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .mem_data(mem[rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH]]),
      .data    (rd_data[k*DATA_WIDTH +: DATA_WIDTH])
    );
  end
endmodule

// File: tb/tb_regfile_sync_mp.sv
// tb_regfile_sync_mp: directed plus random stimulus on a plain and a zero-register instance,
// checked against an array-based reference model
module tb_regfile_sync_mp;
  localparam int DW = 16, AW = 5, NR = 3, DEPTH = 32;
  logic clk = 1'b0, rst_n = 1'b1;
  logic [NR-1:0]    rd_en;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data, rd_data_z;
  logic             wr_en, clr_req, busy, busy_z, wr_drop, wr_drop_z;
  logic [AW-1:0]    wr_addr;
  logic [DW-1:0]    wr_data;
  int checks = 0, failures = 0;
  logic [DW-1:0] mm [2][DEPTH];
  logic [DW-1:0] er [2][NR];
  bit mb, ewd;
  int sp;
  always #5 clk = ~clk;
  regfile_sync_mp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD(NR), .ZERO_REG(0)) dut (
    .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .clr_req(clr_req),
    .busy(busy), .wr_drop(wr_drop));
  regfile_sync_mp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD(NR), .ZERO_REG(1)) dut_z (
    .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_z),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .clr_req(clr_req),
    .busy(busy_z), .wr_drop(wr_drop_z));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [DW-1:0] rdp(input logic [NR*DW-1:0] v, input int k);
    return v[k*DW +: DW];
  endfunction
  task automatic model_reset();
    for (int z = 0; z < 2; z++) begin
      for (int i = 0; i < DEPTH; i++) mm[z][i] = '0;
      for (int k = 0; k < NR; k++) er[z][k] = '0;
    end
    mb = 0; sp = 0; ewd = 0;
  endtask
  task automatic check_all();
    for (int z = 0; z < 2; z++)
      for (int k = 0; k < NR; k++)
        chk($sformatf("rd%0d_z%0d", k, z), z == 1 ? rdp(rd_data_z, k) : rdp(rd_data, k), er[z][k]);
    chk("busy", busy, mb);
    chk("busy_z", busy_z, mb);
    chk("wr_drop", wr_drop, ewd);
    chk("wr_drop_z", wr_drop_z, ewd);
  endtask
  task automatic step();
    for (int z = 0; z < 2; z++) begin
      bit wacc;
      wacc = wr_en && !mb && !(z == 1 && wr_addr == 0);
      for (int k = 0; k < NR; k++) begin
        logic [AW-1:0] a;
        a = rd_addr[k*AW +: AW];
        if (rd_en[k])
          er[z][k] = (z == 1 && a == 0)       ? '0 :
                     (mb && sp == int'(a))     ? '0 :
                     (wacc && wr_addr == a)    ? wr_data : mm[z][a];
      end
      if (mb) mm[z][sp] = '0;
      if (wacc) mm[z][wr_addr] = wr_data;
    end
    ewd = wr_en && mb;
    if (mb) begin
      sp++;
      if (sp == DEPTH) begin mb = 0; sp = 0; end
    end else if (clr_req) begin
      mb = 1; sp = 0;
    end
    @(posedge clk);
    #1;
    check_all();
  endtask
  task automatic idle_in();
    rd_en = '0; rd_addr = '0; wr_en = 0; wr_addr = '0; wr_data = '0; clr_req = 0;
  endtask
  task automatic set_rd(input int k, input logic [AW-1:0] a);
    rd_en[k] = 1'b1;
    rd_addr[k*AW +: AW] = a;
  endtask
  task automatic sweep(input bit extras);
    int cnt, c;
    idle_in(); clr_req = 1; step(); idle_in();
    chk("busy_rise", busy, 1);
    cnt = busy ? 1 : 0;
    c = 1;
    while (busy && c < 100) begin
      idle_in();
      if (extras && c == 5) begin wr_en = 1; wr_addr = 2; wr_data = 16'hAAAA; end
      if (extras && c == 10) set_rd(0, 31);
      step();
      if (extras && c == 5) chk("drop_pulse", wr_drop, 1);
      if (extras && c == 10) chk("busy_rd31", rdp(rd_data, 0), 16'h011F);
      if (busy) cnt++;
      c++;
    end
    chk("busy_len", cnt, 32);
  endtask
  initial begin
    idle_in();
    model_reset();
    #2 rst_n = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    check_all();
    chk("rst_rd", rd_data, 0);
    idle_in(); set_rd(0, 0); set_rd(1, 5); set_rd(2, 31); step();
    chk("rst_read", rd_data, 0);
    idle_in(); wr_en = 1; wr_addr = 7; wr_data = 16'hBEEF; step();
    idle_in(); set_rd(1, 7); step();
    chk("wr_rd_lat", rdp(rd_data, 1), 16'hBEEF);
    idle_in(); wr_en = 1; wr_addr = 3; wr_data = 16'h1234;
    for (int k = 0; k < NR; k++) set_rd(k, 3);
    step();
    for (int k = 0; k < NR; k++) chk($sformatf("bypass%0d", k), rdp(rd_data, k), 16'h1234);
    idle_in(); rd_addr = '1; step();
    for (int k = 0; k < NR; k++) chk($sformatf("hold%0d", k), rdp(rd_data, k), 16'h1234);
    for (int i = 0; i < DEPTH; i++) begin
      idle_in(); wr_en = 1; wr_addr = AW'(i); wr_data = DW'(16'h100 + i); step();
    end
    sweep(1);
    for (int i = 0; i < DEPTH; i++) begin
      idle_in(); set_rd(0, AW'(i)); step();
      chk($sformatf("post_clr%0d", i), rdp(rd_data, 0), 0);
    end
    idle_in(); wr_en = 1; wr_addr = 0; wr_data = 16'hFFFF; step();
    chk("zr_drop", wr_drop_z, 0);
    idle_in(); set_rd(0, 0); step();
    chk("zr_rd0", rdp(rd_data_z, 0), 0);
    chk("nz_rd0", rdp(rd_data, 0), 16'hFFFF);
    idle_in(); clr_req = 1; step(); idle_in();
    repeat (11) step();
    chk("pre_rst_busy", busy, 1);
    rst_n = 0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_busy_z", busy_z, 0);
    model_reset();
    check_all();
    @(posedge clk); @(posedge clk);
    #1 rst_n = 1;
    sweep(0);
    repeat (3000) begin
      rd_en   = NR'($urandom);
      rd_addr = (NR*AW)'($urandom);
      wr_en   = 1'($urandom_range(0, 1));
      wr_addr = AW'($urandom);
      wr_data = DW'($urandom);
      clr_req = ($urandom_range(0, 59) == 0);
      step();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
